// File: rtl/deser_pkg.sv
// Shared types and defaults for the deser_s 1:WIDTH serial-to-parallel deserializer.
package deser_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int IDX_W_DEFAULT = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } deser_state_t;

endpackage : deser_pkg

// File: rtl/deser_s.sv
// Sequential 1:WIDTH deserializer: accepted bit k lands in out[k]; the finished word
// is published with a one-cycle out_valid pulse, and out never shows a partial word.
module deser_s
    import deser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    deser_state_t     state_r;
    // The top bit never needs storing: it arrives on the completing edge and goes straight to out.
    logic [WIDTH-2:0] shadow_r;

    // FSM, accumulation register and all registered outputs; clear outranks in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shadow_r  <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idx       <= IDX_ZERO;
        end else if (clear) begin
            state_r   <= IDLE;
            shadow_r  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idx       <= IDX_ZERO;
        end else begin
            out_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        shadow_r[0] <= in_bit;
                        idx         <= IDX_ONE;
                        busy        <= 1'b1;
                        state_r     <= COLLECT;
                    end else begin
                        idx         <= IDX_ZERO;
                        busy        <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        if (idx == IDX_LAST) begin
                            out       <= {in_bit, shadow_r};
                            out_valid <= 1'b1;
                            idx       <= IDX_ZERO;
                            busy      <= 1'b0;
                            state_r   <= IDLE;
                        end else begin
                            shadow_r[idx] <= in_bit;
                            idx           <= idx + IDX_ONE;
                        end
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    shadow_r  <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    idx       <= IDX_ZERO;
                end
            endcase
        end
    end

endmodule : deser_s

// File: tb/tb_deser_s.sv
// Directed self-checking bench for deser_s: reset, round trip, back-to-back with gaps,
// clear mid-word, clear on the last bit and reset mid-word.
module tb_deser_s;

    logic        clk;
    logic        rst_n;
    logic        in_bit;
    logic        in_valid;
    logic        clear;
    logic [15:0] out;
    logic        out_valid;
    logic        busy;
    logic [3:0]  idx;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_pulse = -1;

    deser_s dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .clear     (clear),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .idx       (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, advance one edge, observe 1 ns after it.
    task automatic send_bit(input logic b, input logic v, input logic c);
        in_bit   = b;
        in_valid = v;
        clear    = c;
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid === 1'b1) last_pulse = cyc;
    endtask

    // Sends a word LSB-first, optionally with one idle cycle before each bit.
    task automatic send_word(input string name, input logic [15:0] w, input logic gap,
                             input logic [15:0] prev);
        for (int k = 0; k < 16; k++) begin
            if (gap) begin
                send_bit(1'b0, 1'b0, 1'b0);
                checks++;
                if (out_valid !== 1'b0 || out !== prev || idx !== 4'(k)) begin
                    errors++;
                    $display("FAIL %s gap%0d: out_valid=%b out=%h idx=%0d, required 0 %h %0d",
                             name, k, out_valid, out, idx, prev, k);
                end
            end
            send_bit(w[k], 1'b1, 1'b0);
            checks++;
            if (k < 15) begin
                if (out_valid !== 1'b0 || out !== prev || idx !== 4'(k + 1) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s bit%0d: out_valid=%b out=%h idx=%0d busy=%b, required 0 %h %0d 1",
                             name, k, out_valid, out, idx, busy, prev, k + 1);
                end
            end else begin
                if (out_valid !== 1'b1 || out !== w || idx !== 4'd0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done: out_valid=%b out=%h idx=%0d busy=%b, required 1 %h 0 0",
                             name, out_valid, out, idx, busy, w);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        checks++;
        if (out !== 16'h0000 || out_valid !== 1'b0 || busy !== 1'b0 || idx !== 4'd0) begin
            errors++;
            $display("FAIL reset: out=%h out_valid=%b busy=%b idx=%0d, required 0000 0 0 0",
                     out, out_valid, busy, idx);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_round_trip();
        send_word("round_trip", 16'h3f0a, 1'b0, 16'h0000);
        send_bit(1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out !== 16'h3f0a) begin
            errors++;
            $display("FAIL round_trip hold: out_valid=%b out=%h, required 0 3f0a", out_valid, out);
        end
    endtask

    task automatic test_back_to_back();
        int c1;
        int c2;
        send_word("b2b_a5a5", 16'hA5A5, 1'b0, 16'h3f0a);
        c1 = last_pulse;
        send_word("b2b_ffff", 16'hFFFF, 1'b0, 16'hA5A5);
        c2 = last_pulse;
        checks++;
        if (c2 - c1 !== 16) begin
            errors++;
            $display("FAIL b2b spacing1: got %0d cycles, required 16", c2 - c1);
        end
        send_word("gap_0001", 16'h0001, 1'b1, 16'hFFFF);
        checks++;
        if (last_pulse - c2 !== 32) begin
            errors++;
            $display("FAIL b2b spacing2: got %0d cycles, required 32", last_pulse - c2);
        end
    endtask

    task automatic test_clear_mid_word();
        for (int k = 0; k < 7; k++) send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        checks++;
        if (idx !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0 || out !== 16'h0001) begin
            errors++;
            $display("FAIL clear_mid: idx=%0d busy=%b out_valid=%b out=%h, required 0 0 0 0001",
                     idx, busy, out_valid, out);
        end
        send_word("after_clear", 16'h1234, 1'b0, 16'h0001);
    endtask

    task automatic test_clear_last_bit();
        for (int k = 0; k < 15; k++) send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out !== 16'h1234 || idx !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_last: out_valid=%b out=%h idx=%0d busy=%b, required 0 1234 0 0",
                     out_valid, out, idx, busy);
        end
        send_bit(1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out !== 16'h1234) begin
            errors++;
            $display("FAIL clear_last after: out_valid=%b out=%h, required 0 1234", out_valid, out);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] w;
        w = 16'hBEEF;
        for (int k = 0; k < 9; k++) send_bit(w[k], 1'b1, 1'b0);
        rst_n = 1'b0;
        send_bit(1'b1, 1'b1, 1'b0);
        checks++;
        if (out !== 16'h0000 || out_valid !== 1'b0 || busy !== 1'b0 || idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: out=%h out_valid=%b busy=%b idx=%0d, required 0000 0 0 0",
                     out, out_valid, busy, idx);
        end
        rst_n = 1'b1;
        send_word("after_reset", 16'hBEEF, 1'b0, 16'h0000);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_bit   = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        test_reset();
        test_round_trip();
        test_back_to_back();
        test_clear_mid_word();
        test_clear_last_bit();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_deser_s

// File: doc/deser_s.md
# deser_s

Sequential 1:16 serial-to-parallel deserializer; the receive-side counterpart of the `mux_s` bit selector. A producer that walks `mux_s` `sel` from 0 to 15 emits one bit per step. This block writes each accepted bit into word position `idx`, which runs 0 to 15, and publishes the finished 16-bit word with a one-cycle valid pulse. It sits downstream of any bit-serial source in the design and reconstructs the word that was serialized.

## Interface
Parameters:
- `WIDTH`, 16: word width in bits; must be a power of two, at least 2.
- `IDX_W`, 4: index width; must equal $clog2(WIDTH).

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `in_bit`, input, 1: serial data bit.
- `in_valid`, input, 1: `in_bit` is accepted on this edge. There is no backpressure; the block always accepts.
- `clear`, input, 1: synchronous abort. Discards the partial word and returns `idx` to 0.
- `out`, output, WIDTH: last completed word. Held stable until the next word completes.
- `out_valid`, output, 1: one-cycle pulse when `out` updates.
- `busy`, output, 1: high while a partial word is held.
- `idx`, output, IDX_W: bit position the next accepted bit will occupy.

## Operation
- FSM has two states: IDLE and COLLECT.
  - IDLE: `busy`=0 and `idx`=0. If `in_valid`=1, the bit goes to `shadow[0]`, `idx` becomes 1, and the FSM moves to COLLECT.
  - COLLECT: `busy`=1. If `in_valid`=1 and `idx`<WIDTH-1, the bit goes to `shadow[idx]` and `idx` increments.
  - COLLECT completion: if `in_valid`=1 and `idx`=WIDTH-1, `out` takes {`in_bit`, `shadow[WIDTH-2:0]`}, `out_valid` is set to 1, `idx` returns to 0, and the FSM returns to IDLE.
  - If `in_valid`=0, the state holds and nothing changes; gaps of any length between bits are allowed.
- Bit ordering: the k-th accepted bit (k from 0) lands in `out[k]`. This matches `mux_s` driven with `sel`=k, so `out` equals the original `in`.
- `shadow` is a private accumulation register, separate from `out`, so `out` never shows a partial word.
- `clear`=1 in either state: FSM goes to IDLE, `idx` to 0, `shadow` to 0. `out` is unchanged and `out_valid` is 0.
- Simultaneous `clear` and `in_valid`: `clear` wins and the bit is dropped. This also applies on the completing (WIDTH-1) bit; no word is emitted.
- `idx` wraps from WIDTH-1 to 0 only through completion. There is no overflow state.

## Timing
- Reset values (`rst_n`=0 on an edge): `out`=0, `out_valid`=0, `busy`=0, `idx`=0, `shadow`=0, state IDLE.
- Reset mid-word behaves as `clear` and additionally zeroes `out`.
- Latency: `out` and `out_valid` are registered.
  - `out_valid` is high in the cycle after the edge that samples the WIDTH-th bit.
  - Exactly 1 cycle from the last bit to the word.
- Throughput: one word per WIDTH cycles with `in_valid` held high.
  - The edge that completes word n can be followed on the next edge by bit 0 of word n+1.
  - `out_valid` then pulses once every WIDTH cycles.
- `out_valid` is never high for two consecutive cycles when WIDTH≥2.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `deser_pkg` contains:
  - `WIDTH_DEFAULT`=16.
  - The state typedef `deser_state_t` {IDLE, COLLECT}.
  - Package values are used as the parameter defaults.
- No sub-module is required. The index counter and bit-write decode stay inline, giving an estimated 120–160 lines.
- An optional wrapper `mux_s_loop` (`mux_s` plus `deser_s`, with `sel` driven from `idx`) is used only by the bench, not in the design.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, then release. Required: `out`=0x0000, `out_valid`=0, `busy`=0, `idx`=0.
- Round trip: source word 0x3f0a, bits sent LSB-first (0,1,0,1,0,0,0,0,1,1,1,1,1,1,0,0), `in_valid` held high for 16 cycles. Required:
  - `out`=0x3f0a with a single `out_valid` pulse exactly 1 cycle after the 16th bit.
  - `idx` steps 0→15→0.
- Back-to-back with gaps: send 0xA5A5, then 0xFFFF with no idle cycle between words, then 0x0001 with `in_valid` low on every other cycle. Required:
  - Three pulses; the first two are exactly 16 cycles apart and the third follows after 32 cycles.
  - Words are 0xA5A5, 0xFFFF, 0x0001.
  - `out` holds each value between pulses.
- Clear mid-word: send 7 bits, then `clear` for 1 cycle, then a full 0x1234. Required:
  - `idx`=0 and `busy`=0 after the clear.
  - No pulse for the partial word; the next `out`=0x1234.
  - `out` keeps its previous value throughout.
- Clear collides with the last bit: `clear` and `in_valid` both high on bit 15. Required: no `out_valid`, `out` unchanged, `idx`=0.
- Reset mid-word: `rst_n`=0 after 9 bits. Required: all outputs at their reset values on the next edge; a fresh 0xBEEF then decodes correctly.
